// File: rtl/motor_pkg.sv
// Shared types, constants and the command saturation helper for motor_pwm.
package motor_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam int DUTY_MAX = 255;

  typedef logic signed [8:0] cmd_t;
  typedef logic [7:0]        duty_t;

  // Clamp a 10-bit mixed command into the +/-DUTY_MAX range.
  function automatic cmd_t sat_cmd(input logic signed [9:0] v);
    cmd_t r;
    if (v > 10'sd255)
      r = 9'sd255;
    else if (v < -10'sd255)
      r = -9'sd255;
    else
      r = v[8:0];
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One motor side: ramped current command, duty/dir registers and PWM compare.
// MOTOR_RAMP_EN defined: limited step per period; undefined: jump to target.
module pwm_channel
  import motor_pkg::*;
#(
  parameter int RAMP_STEP = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              boundary,
  input  logic signed [8:0] tgt,
  input  logic        [7:0] period,
  output logic              pwm,
  output logic              dir,
  output logic signed [8:0] cur
);

`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  // A step of 510 spans the full command range, so the unramped build is the
  // same datapath reaching the target in a single boundary.
  localparam int STEP_I = !RAMP_EN ? 510 : ((RAMP_STEP > 510) ? 510 : RAMP_STEP);

  logic signed [9:0] cur_w;
  logic signed [9:0] tgt_w;
  logic signed [9:0] diff;
  logic signed [9:0] step;
  logic signed [9:0] cand;
  logic signed [9:0] nxt;
  duty_t             duty;

  always_comb begin
    cur_w = {cur[8], cur};
    tgt_w = {tgt[8], tgt};
    step  = 10'(STEP_I);
    diff  = tgt_w - cur_w;
    if (diff > step)
      cand = cur_w + step;
    else if (diff < -step)
      cand = cur_w - step;
    else
      cand = tgt_w;
    nxt = cand;
    // Direction reversals always rest at zero for one period.
    if (RAMP_EN && (((cur_w > 10'sd0) && (cand < 10'sd0)) ||
                    ((cur_w < 10'sd0) && (cand > 10'sd0))))
      nxt = '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cur  <= '0;
      duty <= '0;
      dir  <= 1'b1;
    end else if (boundary) begin
      cur  <= nxt[8:0];
      duty <= nxt[9] ? 8'(-nxt) : nxt[7:0];
      dir  <= ~nxt[9];
    end
  end

  assign pwm = (period < duty);

endmodule

// File: rtl/motor_pwm.sv
// Differential-drive PWM controller: mixing, prescaler, period counter, watchdog, FSM.
// Optional MOTOR_RAMP_EN enables duty ramping in the pwm_channel instances.
module motor_pwm
  import motor_pkg::*;
#(
  parameter int PRESCALE        = 390,
  parameter int WATCHDOG_CYCLES = 10_000_000,
  parameter int RAMP_STEP       = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic signed [8:0] speed,
  input  logic signed [8:0] turn,
  input  logic              cmd_valid,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic              dir_l,
  output logic              dir_r,
  output logic              enable,
  output logic              timeout
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

  state_t            state_q;
  state_t            state_d;
  logic [PW-1:0]     presc;
  duty_t             period;
  logic [WW-1:0]     wd;
  logic              tick;
  logic              boundary;
  logic              expire;
  logic signed [9:0] sum_l;
  logic signed [9:0] sum_r;
  cmd_t              tgt_l;
  cmd_t              tgt_r;
  cmd_t              cur_l;
  cmd_t              cur_r;
  logic              raw_pwm_l;
  logic              raw_pwm_r;

  assign tick     = (presc == PW'(PRESCALE - 1));
  assign boundary = tick && (period == duty_t'(DUTY_MAX - 1));
  assign sum_l    = {speed[8], speed} + {turn[8], turn};
  assign sum_r    = {speed[8], speed} - {turn[8], turn};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      presc  <= '0;
      period <= '0;
    end else if (tick) begin
      presc  <= '0;
      period <= (period == duty_t'(DUTY_MAX - 1)) ? '0 : period + 8'd1;
    end else begin
      presc  <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      wd <= '0;
    else if (cmd_valid || (state_q != RUN))
      wd <= '0;
    else
      wd <= wd + WW'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tgt_l <= '0;
      tgt_r <= '0;
    end else if (cmd_valid) begin
      tgt_l <= sat_cmd(sum_l);
      tgt_r <= sat_cmd(sum_r);
    end else if (expire) begin
      tgt_l <= '0;
      tgt_r <= '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      timeout <= expire;
    end
  end

  always_comb begin
    state_d = state_q;
    expire  = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) state_d = RUN;
      RUN: begin
        if (!cmd_valid && (wd == WW'(WATCHDOG_CYCLES - 1))) begin
          expire  = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cmd_valid)
          state_d = RUN;
        else if (boundary && (cur_l == '0) && (cur_r == '0))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_left (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .boundary (boundary),
    .tgt      (tgt_l),
    .period   (period),
    .pwm      (raw_pwm_l),
    .dir      (dir_l),
    .cur      (cur_l)
  );

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_right (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .boundary (boundary),
    .tgt      (tgt_r),
    .period   (period),
    .pwm      (raw_pwm_r),
    .dir      (dir_r),
    .cur      (cur_r)
  );

  assign enable = (state_q != IDLE);
  assign pwm_l  = raw_pwm_l & enable;
  assign pwm_r  = raw_pwm_r & enable;

endmodule

// File: tb/tb_motor_pwm.sv
// Self-checking bench for motor_pwm: directed tables, multi-cycle sequences and
// randomized commands compared every cycle against an arithmetic reference model.
module tb_motor_pwm;

  localparam int P    = 1;
  localparam int WD   = 2000;
  localparam int STEP = 4;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STOP = 2;

  logic              clk_in    = 1'b0;
  logic              rst_in    = 1'b1;
  logic signed [8:0] speed     = '0;
  logic signed [8:0] turn      = '0;
  logic              cmd_valid = 1'b0;
  logic              pwm_l, pwm_r, dir_l, dir_r, enable, timeout;

  motor_pwm #(.PRESCALE(P), .WATCHDOG_CYCLES(WD), .RAMP_STEP(STEP)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .speed     (speed),
    .turn      (turn),
    .cmd_valid (cmd_valid),
    .pwm_l     (pwm_l),
    .pwm_r     (pwm_r),
    .dir_l     (dir_l),
    .dir_r     (dir_r),
    .enable    (enable),
    .timeout   (timeout)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model: time is counted in clock edges since reset release.
  int edges, last_strobe, m_mode, m_tgt_l, m_tgt_r, m_cur_l, m_cur_r;
  bit m_timeout;
  bit keepalive;
  int cmd_speed, cmd_turn;

  typedef struct { int sp; int tn; int dl; int dr; int xl; int xr; } vec_t;
  typedef struct { int duty; int dir; } rev_t;
  vec_t mix_tbl[5];
  rev_t rev_tbl[4];

  function automatic int sat(input int v);
    return (v > 255) ? 255 : ((v < -255) ? -255 : v);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int toward(input int c, input int t);
    int n;
    if (!RAMP) return t;
    if (iabs(t - c) <= STEP) n = t;
    else n = (t > c) ? c + STEP : c - STEP;
    if ((c > 0 && n < 0) || (c < 0 && n > 0)) n = 0;
    return n;
  endfunction

  function automatic logic [5:0] model_outs();
    int per;
    bit on;
    logic [5:0] o;
    per  = (edges / P) % 255;
    on   = (m_mode != M_IDLE);
    o[5] = on && (per < iabs(m_cur_l));
    o[4] = on && (per < iabs(m_cur_r));
    o[3] = (m_cur_l >= 0);
    o[2] = (m_cur_r >= 0);
    o[1] = on;
    o[0] = m_timeout;
    return o;
  endfunction

  task automatic model_reset();
    edges = 0; last_strobe = 0; m_mode = M_IDLE;
    m_tgt_l = 0; m_tgt_r = 0; m_cur_l = 0; m_cur_r = 0; m_timeout = 1'b0;
  endtask

  task automatic model_step(input bit s, input int sp, input int tn);
    bit bnd;
    int old_l, old_r;
    bnd   = ((edges % P) == P - 1) && (((edges / P) % 255) == 254);
    old_l = m_cur_l;
    old_r = m_cur_r;
    edges++;
    if (bnd) begin
      m_cur_l = toward(m_cur_l, m_tgt_l);
      m_cur_r = toward(m_cur_r, m_tgt_r);
    end
    m_timeout = 1'b0;
    if (s) begin
      m_tgt_l = sat(sp + tn);
      m_tgt_r = sat(sp - tn);
      m_mode = M_RUN;
      last_strobe = edges;
    end else if (m_mode == M_RUN && (edges - last_strobe) == WD) begin
      m_timeout = 1'b1;
      m_mode = M_STOP;
      m_tgt_l = 0;
      m_tgt_r = 0;
    end else if (m_mode == M_STOP && bnd && old_l == 0 && old_r == 0) begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit strobe);
    bit s;
    s = strobe || (keepalive && (edges - last_strobe >= 1000));
    speed = 9'(cmd_speed);
    turn = 9'(cmd_turn);
    cmd_valid = s;
    @(posedge clk_in);
    model_step(s, cmd_speed, cmd_turn);
    #1;
    cmd_valid = 1'b0;
    check("outs", int'({pwm_l, pwm_r, dir_l, dir_r, enable, timeout}), int'(model_outs()));
  endtask

  task automatic strobe_cmd(input int sp, input int tn);
    cmd_speed = sp;
    cmd_turn = tn;
    tick(1'b1);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    keepalive = 1'b0;
    cmd_speed = 0;
    cmd_turn = 0;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("reset_outs", int'({pwm_l, pwm_r, dir_l, dir_r, enable, timeout}), 12);
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic sync_boundary();
    for (int n = 0; n < 300 * P && ((edges % (255 * P)) != 0); n++) tick(1'b0);
  endtask

  task automatic measure(output int hl, output int hr, output int dl, output int dr);
    hl = 0; hr = 0;
    dl = int'(dir_l);
    dr = int'(dir_r);
    for (int i = 0; i < 255 * P; i++) begin
      hl += int'(pwm_l);
      hr += int'(pwm_r);
      tick(1'b0);
    end
  endtask

  initial begin
    int hl, hr, dl, dr, s, tpulse, tedge, n, gap;

    mix_tbl[0] = '{5, 3, 8, 2, 1, 1};
    mix_tbl[1] = '{-2, 4, 2, 6, 1, 0};
    mix_tbl[2] = '{-6, 2, 4, 8, 0, 0};
    mix_tbl[3] = '{0, -7, 7, 7, 0, 1};
    mix_tbl[4] = '{3, 3, 6, 0, 1, 1};
    rev_tbl[0].duty = RAMP ? 4 : 8;  rev_tbl[0].dir = RAMP ? 1 : 0;
    rev_tbl[1].duty = RAMP ? 0 : 8;  rev_tbl[1].dir = RAMP ? 1 : 0;
    rev_tbl[2].duty = RAMP ? 4 : 8;  rev_tbl[2].dir = 0;
    rev_tbl[3].duty = 8;             rev_tbl[3].dir = 0;

    do_reset();

    // Start-up ramp to 100 on both sides.
    strobe_cmd(100, 0);
    keepalive = 1'b1;
    check("enable_run", int'(enable), 1);
    sync_boundary();
    for (int k = 1; k <= 26; k++) begin
      measure(hl, hr, dl, dr);
      check("ramp_duty_l", hl, RAMP ? ((4 * k < 100) ? 4 * k : 100) : 100);
      check("ramp_duty_r", hr, RAMP ? ((4 * k < 100) ? 4 * k : 100) : 100);
    end

    // Left side saturates at full duty.
    strobe_cmd(200, 100);
    sync_boundary();
    repeat (40 * 255 * P) tick(1'b0);
    measure(hl, hr, dl, dr);
    check("sat_duty_l", hl, 255);
    check("sat_duty_r", hr, 100);

    // Reversal through zero.
    do_reset();
    strobe_cmd(8, 0);
    keepalive = 1'b1;
    sync_boundary();
    repeat (3 * 255 * P) tick(1'b0);
    repeat (5) tick(1'b0);
    strobe_cmd(-8, 0);
    sync_boundary();
    for (int i = 0; i < 4; i++) begin
      measure(hl, hr, dl, dr);
      check("rev_duty_l", hl, rev_tbl[i].duty);
      check("rev_dir_l", dl, rev_tbl[i].dir);
    end

    // Mixing table, each entry settled before measuring.
    for (int i = 0; i < 5; i++) begin
      strobe_cmd(mix_tbl[i].sp, mix_tbl[i].tn);
      sync_boundary();
      repeat (5 * 255 * P) tick(1'b0);
      measure(hl, hr, dl, dr);
      check("mix_duty_l", hl, mix_tbl[i].dl);
      check("mix_duty_r", hr, mix_tbl[i].dr);
      check("mix_dir_l", dl, mix_tbl[i].xl);
      check("mix_dir_r", dr, mix_tbl[i].xr);
    end

    // Watchdog expiry, ramp down, return to idle.
    do_reset();
    strobe_cmd(8, 0);
    s = edges;
    tpulse = 0;
    tedge = -1;
    n = 0;
    while (enable && n < 4000) begin
      tick(1'b0);
      if (timeout) begin
        tpulse++;
        if (tedge < 0) tedge = edges;
      end
      n++;
    end
    check("wd_pulse_edge", tedge - s, WD);
    check("wd_pulse_count", tpulse, 1);
    check("wd_idle_enable", int'(enable), 0);

    // Strobe on the expiry cycle keeps RUN.
    strobe_cmd(8, 0);
    tpulse = 0;
    repeat (WD - 1) begin
      tick(1'b0);
      tpulse += int'(timeout);
    end
    tick(1'b1);
    tpulse += int'(timeout);
    repeat (300) begin
      tick(1'b0);
      tpulse += int'(timeout);
    end
    check("wd_cmd_wins_pulses", tpulse, 0);
    check("wd_cmd_wins_enable", int'(enable), 1);

    // First-boundary duty, then asynchronous reset mid-period.
    do_reset();
    strobe_cmd(150, 0);
    keepalive = 1'b1;
    sync_boundary();
    measure(hl, hr, dl, dr);
    check("first_period_duty", hl, RAMP ? 4 : 150);
    tick(1'b0);
    tick(1'b0);
    check("pwm_before_rst", int'(pwm_l), 1);
    #2 rst_in = 1'b1;
    #1 check("rst_async_outs", int'({pwm_l, pwm_r, dir_l, dir_r, enable, timeout}), 12);
    do_reset();

    // Randomized commands with random gaps, checked every cycle.
    while (edges < 15000) begin
      strobe_cmd(int'($urandom_range(0, 510)) - 255, int'($urandom_range(0, 510)) - 255);
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20))
                                        : int'($urandom_range(200, 2600));
      repeat (gap) tick(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 390: clk_in cycles per PWM tick (≥1).
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 10_000_000: clk_in cycles without cmd_valid before auto-stop.
REQ-003 SHALL have parameter RAMP_STEP, default 4: max duty change per PWM period.
REQ-004 SHALL have ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- speed  input  9 signed  forward command, range ±255.
- turn  input  9 signed  turn command, range ±255.
- cmd_valid  input  1  one-cycle strobe; speed/turn valid.
- pwm_l, pwm_r  output  1 each  motor PWM.
- dir_l, dir_r  output  1 each  1 = forward.
- enable  output  1  motor driver enable.
- timeout  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-005 On cmd_valid SHALL compute tgt_l = speed+turn and tgt_r = speed−turn in 10-bit signed, saturate to [−255,+255], and latch both on the next clk_in edge.
REQ-006 Prescaler SHALL count 0..PRESCALE−1; each wrap SHALL produce one tick; period counter SHALL advance 0..254 on ticks, then wrap to 0 (period = 255 ticks).
REQ-007 Period boundary SHALL be the tick on which the period counter wraps 254→0; cur_l/cur_r and duty SHALL update only there (glitch-free).
REQ-008 At each boundary, cur SHALL move toward tgt by min(RAMP_STEP, |tgt−cur|), passing through 0 on sign change; it SHALL never overshoot.
REQ-009 duty = |cur| (8 bits); pwm SHALL be 1 while period counter < duty; duty 255 → constant 1; duty 0 → constant 0.
REQ-010 dir SHALL be 1 when cur ≥ 0, else 0, registered with duty.
REQ-011 FSM states IDLE, RUN, STOP:
- IDLE: enable=0, pwm=0; cmd_valid → RUN.
- RUN: enable=1; watchdog expiry → STOP, tgt_l/tgt_r forced to 0, timeout pulses 1 cycle.
- STOP: enable=1, ramping to 0; cmd_valid → RUN with new targets; cur_l=cur_r=0 at a boundary → IDLE.
REQ-012 Watchdog counter SHALL clear on cmd_valid and count only in RUN; expiry occurs when it reaches WATCHDOG_CYCLES−1.
REQ-013 cmd_valid coinciding with watchdog expiry: cmd_valid wins; stay RUN, no timeout pulse.
REQ-014 cmd_valid coinciding with a period boundary: ramp uses the previous target; the new target applies at the next boundary.
REQ-015 In IDLE, cur and counters SHALL keep running but pwm outputs SHALL be forced to 0.

Reset
REQ-016 rst_in SHALL asynchronously force:
- state IDLE;
- tgt, cur, duty, prescaler, period counter, watchdog = 0;
- pwm_l/pwm_r/enable/timeout = 0, dir_l/dir_r = 1.
REQ-017 Reset asserted mid-period SHALL drop pwm outputs to 0 immediately, without waiting for the clock.

Configuration
REQ-018 Macro MOTOR_RAMP_EN defined: ramping per REQ-008. Undefined: cur SHALL equal tgt at the next boundary, and RAMP_STEP is ignored.

Structure
REQ-019 Package motor_pkg SHALL hold:
- the state enum (IDLE/RUN/STOP);
- DUTY_MAX = 255;
- typedef cmd_t (signed [8:0]);
- typedef duty_t ([7:0]).
REQ-020 Sub-module pwm_channel (one instance per side) SHALL contain: ramp register, boundary update, dir/duty logic, and comparator against the shared period counter. The top SHALL contain the FSM, prescaler, period counter, watchdog and mixing.

Verification (PRESCALE=1, WATCHDOG_CYCLES=2000, RAMP_STEP=4, MOTOR_RAMP_EN defined unless noted)
REQ-021 Reset, then speed=100, turn=0 strobe → RUN, enable=1; duty_l/duty_r = 4, 8, …, 100 at successive boundaries; pwm high 100 of 255 ticks.
REQ-022 speed=200, turn=100 → tgt_l saturates to 255 (pwm_l constant 1 once reached), tgt_r = 100.
REQ-023 From cur_l=+8, strobe speed=−8, turn=0 → cur_l = 4, 0, −4, −8; dir_l falls when cur reaches −4.
REQ-024 No strobe for 2000 cycles in RUN → single timeout pulse, ramp to 0, then IDLE with enable=0; strobe on the expiry cycle → no timeout, stays RUN.
REQ-025 With MOTOR_RAMP_EN undefined, speed=150 → duty=150 at the first boundary; assert rst_in mid-period → pwm_l=0 immediately, all outputs at reset values.
